// File: rtl/range_lfsr16_if.sv
//------------------------------------------------------------------------------
// range_lfsr16_if
// Control and result bundle for the ranged random-number generator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface range_lfsr16_if;
    logic        restart;
    logic        run;
    logic [15:0] offset;
    logic [15:0] limit;
    logic [15:0] out;

    modport master (output restart, output run, output offset, output limit, input out);
    modport slave  (input restart, input run, input offset, input limit, output out);
endinterface

`default_nettype wire

// File: rtl/range_lfsr16.sv
//------------------------------------------------------------------------------
// range_lfsr16
// Free-running 16-bit LFSR reduced into [offset, limit] by a sequential divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_lfsr16 (
    input  wire logic     clk,
    input  wire logic     rst_n,
    range_lfsr16_if.slave bus
);

    localparam logic [15:0] c_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_q;
    logic [15:0] r_dividend;
    logic [16:0] r_span;
    logic [15:0] r_offset;
    logic        r_degen;
    logic [16:0] r_rem;
    logic [3:0]  r_cnt;
    logic [15:0] r_out;

    logic        w_fb;
    logic [16:0] w_span;
    logic        w_degen;
    logic [16:0] w_shift;

    assign w_fb    = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
    assign w_span  = {1'b0, bus.limit} - {1'b0, bus.offset} + 17'd1;
    assign w_degen = (bus.limit < bus.offset);
    // Remainder stays below span (<= 65536), so its low 16 bits carry all information.
    assign w_shift = {r_rem[15:0], r_dividend[r_cnt]};

    assign bus.out = r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= c_SEED;
        end else if (bus.restart) begin
            r_q <= c_SEED;
        end else if (bus.run) begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dividend <= 16'h0000;
            r_span     <= 17'd0;
            r_offset   <= 16'h0000;
            r_degen    <= 1'b0;
            r_rem      <= 17'd0;
            r_cnt      <= 4'd0;
            r_out      <= 16'h0000;
        end else if (bus.restart) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_dividend <= r_q;
                        r_span     <= w_span;
                        r_offset   <= bus.offset;
                        r_degen    <= w_degen;
                        r_rem      <= 17'd0;
                        r_cnt      <= 4'd15;
                        r_state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (w_shift >= r_span) begin
                        r_rem <= w_shift - r_span;
                    end else begin
                        r_rem <= w_shift;
                    end
                    if (r_cnt == 4'd0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_LOAD: begin
                    r_out   <= r_degen ? r_offset : (r_offset + r_rem[15:0]);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_range_lfsr16.sv
//------------------------------------------------------------------------------
// tb_range_lfsr16
// Scoreboard bench: a reference model predicts each draw, the checker compares on load.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_range_lfsr16;

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n;

    range_lfsr16_if bus ();

    range_lfsr16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_q;
    int          m_phase;
    logic        m_load;
    logic [15:0] last_out;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [15:0] draw_of(input logic [15:0] q, input logic [15:0] o, input logic [15:0] l);
        int span;
        if (l < o) return o;
        span = int'(l) - int'(o) + 1;
        return 16'(int'(o) + (int'(q) % span));
    endfunction

    // Reference model: capture on the idle edge, result appears 17 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= c_SEED;
            m_phase <= 0;
            m_load  <= 1'b0;
            exp_q.delete();
        end else begin
            m_load <= 1'b0;
            if (bus.restart) begin
                m_q     <= c_SEED;
                m_phase <= 0;
                exp_q.delete();
            end else begin
                if (bus.run) m_q <= lfsr_next(m_q);
                if (m_phase == 0) begin
                    if (bus.run) begin
                        exp_q.push_back(draw_of(m_q, bus.offset, bus.limit));
                        m_phase <= 1;
                    end
                end else if (m_phase == 17) begin
                    m_load  <= 1'b1;
                    m_phase <= 0;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check16("reset_out", bus.out, 16'h0000);
            last_out = 16'h0000;
        end else if (m_load) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL sb_empty observed=%h expected=none", bus.out);
            end else begin
                check16("sb_draw", bus.out, exp_q.pop_front());
            end
            last_out = bus.out;
        end else begin
            check16("out_stable", bus.out, last_out);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.restart = 1'b0;
        bus.run     = 1'b0;
        bus.offset  = 16'd20;
        bus.limit   = 16'd25;
        last_out    = 16'h0000;
        #1;
        check16("async_reset_out", bus.out, 16'h0000);
        step(3);
        rst_n = 1'b1;
        step(2);
        check16("post_reset_out", bus.out, 16'h0000);

        // First draw after restart uses the seed: 44257 mod 6 = 1.
        bus.restart = 1'b1;
        step(1);
        bus.restart = 1'b0;
        bus.run     = 1'b1;
        step(17);
        check16("first_draw_latency", bus.out, 16'h0000);
        step(1);
        check16("first_draw", bus.out, 16'd21);

        // Long run with a fixed range.
        step(2000);
        check16("range_low_ok", 16'(bus.out >= 16'd20), 16'd1);
        check16("range_high_ok", 16'(bus.out <= 16'd25), 16'd1);

        // Operand changes mid-draw, including degenerate and full ranges.
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: begin bus.offset = 16'(i); bus.limit = 16'(i + $urandom_range(0, 300)); end
                1: begin bus.offset = 16'd9;  bus.limit = 16'd5; end
                2: begin bus.offset = 16'd0;  bus.limit = 16'hFFFF; end
                default: begin
                    bus.offset = 16'($urandom_range(0, 65535));
                    bus.limit  = 16'($urandom_range(0, 65535));
                end
            endcase
            step(7 + (i % 11));
        end

        // Degenerate range direct check.
        bus.restart = 1'b1;
        bus.offset  = 16'd9;
        bus.limit   = 16'd5;
        step(1);
        bus.restart = 1'b0;
        step(18);
        check16("degenerate", bus.out, 16'd9);

        // One run step then idle: next draw exposes the stepped LFSR value.
        bus.run     = 1'b0;
        bus.restart = 1'b1;
        bus.offset  = 16'd0;
        bus.limit   = 16'hFFFF;
        step(1);
        bus.restart = 1'b0;
        bus.run     = 1'b1;
        step(1);
        bus.run = 1'b0;
        step(20);
        check16("first_full_range", bus.out, c_SEED);
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
        step(20);
        check16("lfsr_one_step", bus.out, 16'h59C3);

        // Full-range sweep over a whole LFSR period.
        bus.run = 1'b1;
        step(65540);

        // Restart mid-DIV discards the pending draw.
        bus.offset  = 16'd20;
        bus.limit   = 16'd25;
        bus.restart = 1'b1;
        step(1);
        bus.restart = 1'b0;
        step(8);
        bus.restart = 1'b1;
        bus.offset  = 16'd100;
        bus.limit   = 16'd200;
        step(1);
        bus.restart = 1'b0;
        bus.offset  = 16'd20;
        bus.limit   = 16'd25;
        step(18);
        check16("after_restart_draw", bus.out, 16'd21);

        // Asynchronous reset mid-draw.
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        check16("async_mid_draw", bus.out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(18);
        check16("after_reset_draw", bus.out, 16'd21);

        bus.run = 1'b0;
        step(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/range_lfsr16.md
# range_lfsr16

Pseudo-random number generator that returns values in a programmable inclusive range [offset, limit]. A free-running 16-bit maximal-length LFSR is sampled, and the sample is reduced modulo the span by a 16-step sequential restoring divider. The result is then offset into range. The game logic uses it to draw random delays and counts. It also provides restart control, so the game can reseed and get a repeatable sequence.

## Interface
- No parameters. Seed fixed at 16'hACE1, LFSR width fixed at 16.
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- Restart  input  1  synchronous reseed/abort, active high, priority over Run.
- Run  input  1  enables LFSR stepping and starting new draws.
- offset  input  16  lower bound of the output range, unsigned, inclusive.
- limit  input  16  upper bound of the output range, unsigned, inclusive.
- out  output  16  most recent drawn value, registered.

## Operation
- LFSR, Fibonacci form, polynomial x^16+x^14+x^13+x^11+1.
  - fb = q[15]^q[13]^q[12]^q[10].
  - Next state = {q[14:0], fb}.
  - Period is 65535. The all-zero state is unreachable.
- LFSR update priority, evaluated each clock edge:
  - RST low: q = 16'hACE1.
  - Else Restart = 1: q = 16'hACE1.
  - Else Run = 1: q steps once.
  - Otherwise: q holds.
- Span = limit − offset + 1, computed in 17 bits. Span is 65536 when offset = 0 and limit = 16'hFFFF.
- If limit < offset, the draw result is offset. This is the degenerate range case.
- Draw FSM has three states: IDLE, DIV, LOAD.
  - IDLE with Run = 1 and Restart = 0:
    - Capture the current (pre-step) q as the dividend.
    - Capture span, offset, and the flag (limit < offset).
    - Clear the remainder, set the bit count to 15, go to DIV.
  - DIV: one restoring-division step per cycle, MSB of the dividend first.
    - rem = {rem, next dividend bit}.
    - If rem ≥ span, then rem −= span.
    - After the step for bit 0, go to LOAD.
    - The remainder register is 17 bits.
  - LOAD: out = captured_offset + rem[15:0], or out = captured_offset if the flag is set. Go to IDLE.
- The result always lies in [offset, limit], so the sum cannot overflow 16 bits.
- Operands are captured at draw start. Changes to offset or limit mid-draw do not affect that draw.
- Run falling mid-draw: the current draw completes and updates out. No new draw starts while Run = 0.
- Restart = 1 in any state: the FSM returns to IDLE and the pending draw is discarded. out holds its value.

## Timing
- Reset values: out = 16'h0000, q = 16'hACE1, FSM = IDLE, rem = 0.
- Draw latency: capture at edge N, 16 DIV edges, then out updates at edge N+17.
- The next capture is at edge N+18, so with Run held high out refreshes every 18 cycles.
- The LFSR steps every cycle Run = 1, independent of the FSM. Successive draws therefore use q values 18 steps apart.
- Restart and reset both produce the identical LFSR sequence afterwards.
- out changes only on a LOAD edge or on reset.

## Test plan
- Reset, then Restart pulse, offset = 20, limit = 25, raise Run → first draw uses q = 16'hACE1 (44257). 44257 mod 6 = 1, so out = 21 exactly 17 cycles after the capture edge.
- Same setup, Run held high for 2000 cycles → every out value lies in 20..25, and out changes only every 18 cycles.
- LFSR check: one Run cycle after restart gives q = 16'h59C3. Run for 65535 cycles → q returns to 16'hACE1 and never hits 0.
- offset = 0, limit = 16'hFFFF → out equals the captured q exactly. limit = 5, offset = 9 → out = 9.
- Restart asserted mid-DIV → out keeps its previous value, and the FSM reaches IDLE next cycle. The next draw after restart gives the same result as the first test.
- RST low asynchronously mid-draw → out = 0 immediately with no clock edge. On release, behaviour matches a fresh reset.
